// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - timed 4-phase stepper drive pattern generator with run/abort control
module step_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int STEPS_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic                half_step,
    input  logic                hold_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [STEPS_W-1:0]  steps,
    output logic [3:0]          phase_out,
    output logic                enable_out,
    output logic                busy,
    output logic                step_pulse,
    output logic                done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [2:0]          idx;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] reload;
    logic [STEPS_W-1:0]  rem;
    logic                dir_l;
    logic                half_l;
    logic [2:0]          stride;
    logic [2:0]          next_idx;
    logic [PERIOD_W-1:0] load_val;

    // Only decoder-accepted codes exist here, so the decoder never hits its all-off default.
    function automatic logic [3:0] phase_code(input logic [2:0] i);
        case (i)
            3'd0:    phase_code = 4'b1000;
            3'd1:    phase_code = 4'b1001;
            3'd2:    phase_code = 4'b0001;
            3'd3:    phase_code = 4'b0101;
            3'd4:    phase_code = 4'b0100;
            3'd5:    phase_code = 4'b0110;
            3'd6:    phase_code = 4'b0010;
            default: phase_code = 4'b1010;
        endcase
    endfunction

    always_comb begin
        stride   = half_l ? 3'd1 : 3'd2;
        next_idx = dir_l ? idx + stride : idx - stride;
        // Periods of 0 and 1 behave as 2: the timer counts down to zero from P-1.
        load_val = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            phase_out  <= 4'b1000;
            enable_out <= 1'b0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            timer      <= '0;
            reload     <= '0;
            rem        <= '0;
            dir_l      <= 1'b0;
            half_l     <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    enable_out <= hold_en;
                    if (start && !stop) begin
                        if (steps != '0) begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            enable_out <= 1'b1;
                            dir_l      <= dir;
                            half_l     <= half_step;
                            reload     <= load_val;
                            timer      <= load_val;
                            rem        <= steps;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    enable_out <= 1'b1;
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        enable_out <= hold_en;
                    end else if (timer == '0) begin
                        idx        <= next_idx;
                        phase_out  <= phase_code(next_idx);
                        step_pulse <= 1'b1;
                        rem        <= rem - STEPS_W'(1);
                        timer      <= reload;
                        if (rem == STEPS_W'(1)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            enable_out <= hold_en;
                        end
                    end else begin
                        timer <= timer - PERIOD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
